// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard and issue controller for the ID stage.
// Latency: issue_ready/stall combinational from ID fields + registered counters; counters update next edge.
// Backpressure: issue_ready drops on source hazard, full destination counter, or flush; independent of issue_valid.
//
// Ports:
//   clock, reset_n        : rising-edge clock, async active-low reset
//   flush                 : clears all pending-write counters at the next edge
//   issue_valid/ready     : ID instruction handshake toward the ID/EX register
//   rs, rt, uses_rs/rt    : source operands of the ID instruction
//   rd, RegWrite_id       : destination of the ID instruction
//   wb_valid, writeRegister : writeback committing to the register bank
//   stall                 : issue_valid & ~issue_ready
//   busy_mask             : per-register "has pending writes"
//   stall_count           : saturating stall-cycle counter
//   wb_underflow          : sticky flag, writeback with no pending write
module id_scoreboard #(
    parameter int NREG  = 8,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [2:0]       rs,
    input  logic [2:0]       rt,
    input  logic             uses_rs,
    input  logic             uses_rt,
    input  logic [2:0]       rd,
    input  logic             RegWrite_id,
    input  logic             wb_valid,
    input  logic [2:0]       writeRegister,
    output logic             stall,
    output logic [NREG-1:0]  busy_mask,
    output logic [15:0]      stall_count,
    output logic             wb_underflow
);

    localparam int               IDX_W   = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [15:0]      stall_count_q, stall_count_d;
    logic             wb_underflow_q, wb_underflow_d;

    logic             hazard;
    logic             full;
    logic             issue_fire;
    logic [NREG-1:0]  inc_v;
    logic [NREG-1:0]  dec_v;

    // Hazard and full look only at registered counters: a writeback in the
    // same cycle does not release a dependent instruction until the next cycle.
    always_comb begin
        hazard      = (uses_rs && (cnt_q[rs] != '0)) || (uses_rt && (cnt_q[rt] != '0));
        full        = RegWrite_id && (cnt_q[rd] == CNT_MAX);
        issue_ready = !flush && !hazard && !full;
        stall       = issue_valid && !issue_ready;
        issue_fire  = issue_valid && issue_ready;
    end

    // Per-register increment/decrement requests. A retire of an empty
    // counter is not a decrement; it only raises the underflow flag.
    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int i = 0; i < NREG; i++) begin
            inc_v[i] = issue_fire && RegWrite_id && (rd == IDX_W'(i));
            dec_v[i] = wb_valid && (writeRegister == IDX_W'(i)) && (cnt_q[i] != '0);
        end
    end

    // Simultaneous increment and decrement cancel out. Flush wins over both.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            cnt_d[i] = cnt_q[i];
            if (flush) begin
                cnt_d[i] = '0;
            end else if (inc_v[i] && !dec_v[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec_v[i] && !inc_v[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        wb_underflow_d = wb_underflow_q;
        if (!flush && wb_valid && (cnt_q[writeRegister] == '0)) begin
            wb_underflow_d = 1'b1;
        end
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
            stall_count_q  <= 16'd0;
            wb_underflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stall_count_q  <= stall_count_d;
            wb_underflow_q <= wb_underflow_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < NREG; i++) begin
            busy_mask[i] = (cnt_q[i] != '0);
        end
    end

    assign stall_count  = stall_count_q;
    assign wb_underflow = wb_underflow_q;

endmodule
